integral_image_gen: RTL

INTEGRAL_IMAGE_GEN -- requirements
Module: integral_image_gen

---
 rtl/integral_image_gen_if.sv | 28 ++
 rtl/integral_image_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/integral_image_gen_if.sv
// rtl/integral_image_gen_if.sv - control, pixel-stream and integral-stream bundle for integral_image_gen
interface integral_image_gen_if #(
  parameter int SUM_W = 32
);
  logic             start;
  logic [15:0]      img_w;
  logic [15:0]      img_h;
  logic [7:0]       pix_in;
  logic             pix_valid;
  logic             pix_ready;
  logic [SUM_W-1:0] ii_out;
  logic [31:0]      ii_addr;
  logic             ii_valid;
  logic             ii_ready;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, img_w, img_h, pix_in, pix_valid, ii_ready,
    input  pix_ready, ii_out, ii_addr, ii_valid, busy, done, err
  );

  modport slave (
    input  start, img_w, img_h, pix_in, pix_valid, ii_ready,
    output pix_ready, ii_out, ii_addr, ii_valid, busy, done, err
  );
endinterface

// File: rtl/integral_image_gen.sv
// rtl/integral_image_gen.sv - streaming integral-image generator with one-row line buffer, latency 1.
// Define INTII_SAT_EN for saturating sums; the default build wraps modulo 2^SUM_W.
module integral_image_gen #(
  parameter int MAX_W = 1024,
  parameter int SUM_W = 32
) (
  input logic                 clk,
  input logic                 reset,
  integral_image_gen_if.slave bus
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_RUN   = 2'd1;
  localparam logic [1:0]  S_DRAIN = 2'd2;
  localparam int          AW      = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [31:0] MAX_W32 = MAX_W;

  logic [1:0]       state_q, state_d;
  logic [15:0]      w_q, w_d;
  logic [15:0]      h_q, h_d;
  logic [15:0]      x_q, x_d;
  logic [15:0]      y_q, y_d;
  logic [SUM_W-1:0] row_sum_q, row_sum_d;
  logic [31:0]      addr_q, addr_d;
  logic [SUM_W-1:0] ii_out_q, ii_out_d;
  logic [31:0]      ii_addr_q, ii_addr_d;
  logic             ii_valid_q, ii_valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [SUM_W-1:0] linebuf [MAX_W];

  logic             pix_ready;
  logic             xfer;
  logic             x_last;
  logic             y_last;
  logic             start_ok;
  logic [AW-1:0]    x_idx;
  logic [SUM_W-1:0] pix_ext;
  logic [SUM_W-1:0] above;
  logic [SUM_W-1:0] rs_new;
  logic [SUM_W-1:0] ii_new;

  function automatic logic [SUM_W-1:0] add_sum(input logic [SUM_W-1:0] a,
                                               input logic [SUM_W-1:0] b);
`ifdef INTII_SAT_EN
    logic [SUM_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
`else
    return a + b;
`endif
  endfunction

  assign pix_ready = (state_q == S_RUN) && (!ii_valid_q || bus.ii_ready);
  assign xfer      = bus.pix_valid && pix_ready;
  assign x_last    = (x_q == w_q - 16'd1);
  assign y_last    = (y_q == h_q - 16'd1);
  assign start_ok  = (bus.img_w != 16'd0) && ({16'd0, bus.img_w} <= MAX_W32) &&
                     (bus.img_h != 16'd0);
  assign x_idx     = x_q[AW-1:0];
  assign pix_ext   = SUM_W'(bus.pix_in);

  // Row 0 never reads the line buffer, so a frame abandoned by reset leaves no residue.
  always_comb begin
    rs_new = add_sum((x_q == 16'd0) ? '0 : row_sum_q, pix_ext);
    above  = (y_q == 16'd0) ? '0 : linebuf[x_idx];
    ii_new = add_sum(rs_new, above);
  end

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    h_d        = h_q;
    x_d        = x_q;
    y_d        = y_q;
    row_sum_d  = row_sum_q;
    addr_d     = addr_q;
    ii_out_d   = ii_out_q;
    ii_addr_d  = ii_addr_q;
    ii_valid_d = ii_valid_q;
    done_d     = 1'b0;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (start_ok) begin
            state_d   = S_RUN;
            w_d       = bus.img_w;
            h_d       = bus.img_h;
            x_d       = 16'd0;
            y_d       = 16'd0;
            row_sum_d = '0;
            addr_d    = 32'd0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (xfer) begin
          row_sum_d = rs_new;
          addr_d    = addr_q + 32'd1;
          if (x_last) begin
            x_d = 16'd0;
            y_d = y_q + 16'd1;
            if (y_last) state_d = S_DRAIN;
          end else begin
            x_d = x_q + 16'd1;
          end
        end
      end
      S_DRAIN: begin
        if (ii_valid_q && bus.ii_ready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The output register only advances on a transfer, so a stalled word holds.
    if (xfer) begin
      ii_valid_d = 1'b1;
      ii_out_d   = ii_new;
      ii_addr_d  = addr_q;
    end else if (bus.ii_ready) begin
      ii_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      w_q        <= 16'd0;
      h_q        <= 16'd0;
      x_q        <= 16'd0;
      y_q        <= 16'd0;
      row_sum_q  <= '0;
      addr_q     <= 32'd0;
      ii_out_q   <= '0;
      ii_addr_q  <= 32'd0;
      ii_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      h_q        <= h_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_sum_q  <= row_sum_d;
      addr_q     <= addr_d;
      ii_out_q   <= ii_out_d;
      ii_addr_q  <= ii_addr_d;
      ii_valid_q <= ii_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) linebuf[x_idx] <= ii_new;
  end

  assign bus.pix_ready = pix_ready;
  assign bus.ii_out    = ii_out_q;
  assign bus.ii_addr   = ii_addr_q;
  assign bus.ii_valid  = ii_valid_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
